// File: rtl/cb_desegment_if.sv
// Serial code-block stream from the segmenter and the repacked byte/status stream toward reassembly.
// master drives the serial stream, slave is the desegmenter.
interface cb_desegment_if;
    logic       in_valid;
    logic       data;
    logic       start;
    logic       size;
    logic       last;
    logic       filling;
    logic       crc;
    logic [7:0] out_byte;
    logic [3:0] out_nbits;
    logic       out_valid;
    logic       cb_done;
    logic       cb_crc_ok;
    logic       cb_fmt_err;

    modport master (
        output in_valid, data, start, size, last, filling, crc,
        input  out_byte, out_nbits, out_valid, cb_done, cb_crc_ok, cb_fmt_err
    );

    modport slave (
        input  in_valid, data, start, size, last, filling, crc,
        output out_byte, out_nbits, out_valid, cb_done, cb_crc_ok, cb_fmt_err
    );
endinterface

// File: rtl/cb_desegment.sv
// Code block desegmenter: drops filler, checks CRC24B and length, strips CRC, packs payload MSB-first.
//
// state | meaning
// IDLE  | waiting for a start bit; other bits discarded
// FILL  | leading filler bits of the current block
// DATA  | payload bits, packed into bytes
// CRC   | counting the 24 trailing CRC bits
// CHECK | status cycle (cb_done high); a start here opens the next block
module cb_desegment (
    input  logic          clk,
    input  logic          reset,
    cb_desegment_if.slave bus
);
    typedef enum logic [2:0] {IDLE, FILL, DATA, CRC, CHECK} state_t;

    localparam logic [23:0] CRC_POLY = 24'h800063;
    localparam logic [12:0] K_SMALL  = 13'd1056;
    localparam logic [12:0] K_LARGE  = 13'd6144;

    state_t      state;
    logic        k_large;
    logic        last_blk;
    logic        fmt;
    logic [12:0] bit_cnt;
    logic [4:0]  crc_cnt;
    logic [23:0] crc_reg;
    logic [7:0]  pack_buf;
    logic [2:0]  pack_cnt;

    logic [7:0]  out_byte_r;
    logic [3:0]  out_nbits_r;
    logic        out_valid_r;
    logic        cb_done_r;
    logic        cb_crc_ok_r;
    logic        cb_fmt_err_r;

    logic        mid_blk;
    logic        new_blk;
    logic        abort;
    logic        accept;

    // per-bit context: a start bit evaluates against a freshly cleared block
    logic        b_klarge;
    logic        b_last;
    logic        b_fmt;
    logic [12:0] b_k;
    logic [12:0] b_cnt;
    logic [4:0]  b_ccnt;
    logic [23:0] b_crc;
    logic [7:0]  b_pbuf;
    logic [2:0]  b_pcnt;
    state_t      ph;

    logic        fb;
    logic [23:0] n_crc;
    logic [12:0] n_cnt;
    logic [4:0]  n_ccnt;
    logic        n_fmt;
    logic        pay;
    logic        blk_end;
    state_t      n_state;

    assign mid_blk = (state == FILL) || (state == DATA) || (state == CRC);
    assign new_blk = bus.in_valid && bus.start;
    assign abort   = new_blk && mid_blk;
    assign accept  = bus.in_valid && (bus.start || mid_blk);

    always_comb begin
        b_klarge = new_blk ? bus.size : k_large;
        b_last   = new_blk ? bus.last : last_blk;
        b_fmt    = new_blk ? 1'b0 : fmt;
        b_cnt    = new_blk ? 13'd0 : bit_cnt;
        b_ccnt   = new_blk ? 5'd0 : crc_cnt;
        b_crc    = new_blk ? 24'd0 : crc_reg;
        b_pbuf   = abort ? 8'd0 : pack_buf;
        b_pcnt   = abort ? 3'd0 : pack_cnt;
        b_k      = b_klarge ? K_LARGE : K_SMALL;
        ph       = new_blk ? FILL : state;

        fb    = b_crc[23] ^ bus.data;
        n_crc = {b_crc[22:0], 1'b0} ^ (fb ? CRC_POLY : 24'd0);
        n_cnt = (b_cnt == 13'h1fff) ? b_cnt : b_cnt + 13'd1;

        n_fmt   = b_fmt;
        n_ccnt  = b_ccnt;
        pay     = 1'b0;
        n_state = ph;
        case (ph)
            FILL: begin
                if (!bus.filling) begin
                    if (bus.crc) begin
                        n_state = CRC;
                        n_ccnt  = 5'd1;
                    end else begin
                        n_state = DATA;
                        pay     = 1'b1;
                    end
                end
            end
            DATA: begin
                if (bus.filling) begin
                    n_fmt = 1'b1;
                end else if (bus.crc) begin
                    n_state = CRC;
                    n_ccnt  = 5'd1;
                end else begin
                    pay = 1'b1;
                end
            end
            CRC: begin
                // every bit here counts, so a malformed tail still terminates the block
                n_ccnt = b_ccnt + 5'd1;
                if (bus.filling || !bus.crc)
                    n_fmt = 1'b1;
            end
            default: ;
        endcase
        if (n_cnt > b_k)
            n_fmt = 1'b1;
        blk_end = (n_state == CRC) && (n_ccnt == 5'd24);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            k_large      <= 1'b0;
            last_blk     <= 1'b0;
            fmt          <= 1'b0;
            bit_cnt      <= 13'd0;
            crc_cnt      <= 5'd0;
            crc_reg      <= 24'd0;
            pack_buf     <= 8'd0;
            pack_cnt     <= 3'd0;
            out_byte_r   <= 8'd0;
            out_nbits_r  <= 4'd0;
            out_valid_r  <= 1'b0;
            cb_done_r    <= 1'b0;
            cb_crc_ok_r  <= 1'b0;
            cb_fmt_err_r <= 1'b0;
        end else begin
            out_valid_r  <= 1'b0;
            cb_done_r    <= 1'b0;
            cb_crc_ok_r  <= 1'b0;
            cb_fmt_err_r <= 1'b0;

            if (state == CHECK)
                state <= IDLE;

            if (accept) begin
                if (abort) begin
                    cb_done_r    <= 1'b1;
                    cb_fmt_err_r <= 1'b1;
                end
                k_large  <= b_klarge;
                last_blk <= b_last;
                fmt      <= n_fmt;
                bit_cnt  <= n_cnt;
                crc_cnt  <= n_ccnt;
                crc_reg  <= n_crc;

                if (pay) begin
                    pack_buf <= {b_pbuf[6:0], bus.data};
                    if (b_pcnt == 3'd7) begin
                        out_valid_r <= 1'b1;
                        out_byte_r  <= {b_pbuf[6:0], bus.data};
                        out_nbits_r <= 4'd8;
                        pack_cnt    <= 3'd0;
                    end else begin
                        pack_cnt <= b_pcnt + 3'd1;
                    end
                end else begin
                    pack_buf <= b_pbuf;
                    pack_cnt <= b_pcnt;
                end

                if (blk_end) begin
                    state        <= CHECK;
                    cb_done_r    <= 1'b1;
                    cb_crc_ok_r  <= (n_crc == 24'd0) && !n_fmt;
                    cb_fmt_err_r <= n_fmt || (n_cnt != b_k);
                    // residual bits sit in the low end of the shifter; left-align them
                    if (b_last && (b_pcnt != 3'd0)) begin
                        out_valid_r <= 1'b1;
                        out_byte_r  <= b_pbuf << (4'd8 - {1'b0, b_pcnt});
                        out_nbits_r <= {1'b0, b_pcnt};
                        pack_buf    <= 8'd0;
                        pack_cnt    <= 3'd0;
                    end
                end else begin
                    state <= n_state;
                end
            end
        end
    end

    assign bus.out_byte   = out_byte_r;
    assign bus.out_nbits  = out_nbits_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.cb_done    = cb_done_r;
    assign bus.cb_crc_ok  = cb_crc_ok_r;
    assign bus.cb_fmt_err = cb_fmt_err_r;
endmodule
